// File: rtl/count_step_monitor.sv
// count_step_monitor
//   Receive-side decoder for the display-timing step counter. Samples the
//   4-bit count on every valid cycle, recovers the step size (1..3) from
//   consecutive modulo-16 differences, and reports lock, step changes and
//   stream errors. Keeps a saturating error count.
//
// Ports
//   clk       : clock, rising edge
//   rst       : synchronous reset, active low
//   in_valid  : count is sampled on this edge when high
//   count     : counter value under observation (4 bits)
//   clr       : synchronous clear of err_cnt only (wins over an increment)
//   step      : recovered step, 0 when not locked
//   locked    : high while locked
//   step_chg  : one-cycle pulse on a legal step change while locked
//   err_pulse : one-cycle pulse on an illegal delta while locked
//   err_cnt   : saturating error count since reset or clr
module count_step_monitor #(
  parameter int unsigned LOCK_N = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] count,
  input  logic       clr,
  output logic [1:0] step,
  output logic       locked,
  output logic       step_chg,
  output logic       err_pulse,
  output logic [7:0] err_cnt
);

  localparam logic [3:0] LOCK_N4 = 4'(LOCK_N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACQ,
    S_LOCK
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_prev, w_prev_nxt;
  logic [1:0]  r_cand, w_cand_nxt;
  logic [3:0]  r_run, w_run_nxt;
  logic [1:0]  r_step, w_step_nxt;
  logic        r_locked, w_locked_nxt;
  logic        r_chg, w_chg_nxt;
  logic        r_err, w_err_nxt;
  logic [7:0]  r_err_cnt;

  logic [3:0]  w_d;
  logic        w_legal;

  // 4-bit wrapping subtract gives the modulo-16 delta directly
  assign w_d     = count - r_prev;
  assign w_legal = (w_d != 4'd0) && (w_d < 4'd4);

  always_comb begin
    w_state_nxt  = r_state;
    w_prev_nxt   = r_prev;
    w_cand_nxt   = r_cand;
    w_run_nxt    = r_run;
    w_step_nxt   = r_step;
    w_locked_nxt = r_locked;
    w_chg_nxt    = 1'b0;
    w_err_nxt    = 1'b0;
    if (in_valid) begin
      w_prev_nxt = count;
      unique case (r_state)
        S_IDLE: begin
          // seed sample only; no delta yet
          w_cand_nxt  = '0;
          w_run_nxt   = '0;
          w_state_nxt = S_ACQ;
        end
        S_ACQ: begin
          if (!w_legal) begin
            w_cand_nxt = '0;
            w_run_nxt  = '0;
          end else if (w_d[1:0] == r_cand) begin
            w_run_nxt = (r_run >= LOCK_N4) ? r_run : r_run + 4'd1;
          end else begin
            w_cand_nxt = w_d[1:0];
            w_run_nxt  = 4'd1;
          end
          if (w_run_nxt == LOCK_N4) begin
            w_state_nxt  = S_LOCK;
            w_step_nxt   = w_cand_nxt;
            w_locked_nxt = 1'b1;
          end
        end
        S_LOCK: begin
          if (w_d == {2'b00, r_step}) begin
            w_state_nxt = S_LOCK;
          end else if (w_legal) begin
            w_chg_nxt  = 1'b1;
            w_cand_nxt = w_d[1:0];
            w_run_nxt  = 4'd1;
            if (LOCK_N == 1) begin
              // a single delta is already enough to re-lock
              w_step_nxt = w_d[1:0];
            end else begin
              w_state_nxt  = S_ACQ;
              w_locked_nxt = 1'b0;
              w_step_nxt   = '0;
            end
          end else begin
            w_err_nxt    = 1'b1;
            w_state_nxt  = S_ACQ;
            w_cand_nxt   = '0;
            w_run_nxt    = '0;
            w_locked_nxt = 1'b0;
            w_step_nxt   = '0;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_prev    <= '0;
      r_cand    <= '0;
      r_run     <= '0;
      r_step    <= '0;
      r_locked  <= 1'b0;
      r_chg     <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_prev   <= w_prev_nxt;
      r_cand   <= w_cand_nxt;
      r_run    <= w_run_nxt;
      r_step   <= w_step_nxt;
      r_locked <= w_locked_nxt;
      r_chg    <= w_chg_nxt;
      r_err    <= w_err_nxt;
      if (clr) begin
        r_err_cnt <= '0;
      end else if (w_err_nxt && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign step      = r_step;
  assign locked    = r_locked;
  assign step_chg  = r_chg;
  assign err_pulse = r_err;
  assign err_cnt   = r_err_cnt;

endmodule

// File: doc/count_step_monitor.md
# count_step_monitor

Receive-side monitor for the display-timing step counter. It samples the 4-bit counter value each valid cycle and recovers the step size (1, 2 or 3) from consecutive modulo-16 differences. It reports lock status, step changes and stream errors, and keeps a saturating error count. It sits on the counter output bus, upstream of the display control status registers, and is used in-system and in benches as the decoder for the counter's stepped sequence.

## Interface
- LOCK_N, 3: number of consecutive equal valid deltas needed to declare lock. Legal range 1..15.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-low.
- in_valid  input  1  count is sampled on this edge when high.
- count  input  4  counter value under observation.
- clr  input  1  synchronous clear of err_cnt only.
- step  output  2  recovered step. 0 when not locked.
- locked  output  1  high while in LOCK.
- step_chg  output  1  one-cycle pulse on a legal step change while locked.
- err_pulse  output  1  one-cycle pulse on an illegal delta while locked.
- err_cnt  output  8  errors since reset or clr. Saturates at 255.

## Operation
- Delta: d = (count - prev) mod 16, computed as a 4-bit wrapping subtract. Example: prev=15, count=1 gives d=2.
- Legal delta is d in {1,2,3}. d=0 and d≥4 are illegal.
- Internal state:
  - prev[3:0]: last sampled count.
  - cand[1:0]: candidate step.
  - run[3:0]: consecutive equal-delta count, saturates at LOCK_N.
  - FSM: IDLE, ACQ, LOCK.
- IDLE: on in_valid, prev←count, cand←0, run←0, go to ACQ. No outputs change.
- ACQ: on in_valid, prev←count.
  - If d is legal and d==cand: run←run+1.
  - If d is legal and d≠cand: cand←d, run←1.
  - If d is illegal: cand←0, run←0. No err_pulse in ACQ.
  - When the updated run equals LOCK_N: go to LOCK, step←cand, locked←1.
- LOCK: on in_valid, prev←count.
  - d==step: stay in LOCK, no pulse.
  - d legal and d≠step: step_chg←1, go to ACQ, cand←d, run←1, locked←0, step←0.
    - If LOCK_N==1: go straight back to LOCK with step←d, locked stays 1, step_chg still pulses.
  - d illegal: err_pulse←1, err_cnt←err_cnt+1 (saturating at 255), go to ACQ, cand←0, run←0, locked←0, step←0.
- When in_valid is low: no state, prev, cand or run change. Pulses deassert.
- clr=1: err_cnt←0 on that edge.
  - clr beats a simultaneous increment: err_cnt ends at 0.
  - err_pulse still asserts in that case.
- Reset (rst=0 at the edge) overrides all inputs.
  - Values after reset: FSM=IDLE, prev=0, cand=0, run=0, step=0, locked=0, step_chg=0, err_pulse=0, err_cnt=0.
  - The first valid sample after reset is only stored; no delta is evaluated for it.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Timing
- Latency is one cycle. A sample taken at edge k is reflected in the outputs right after edge k.
- Lock with LOCK_N=3 needs 4 valid samples (1 seed + 3 deltas). locked rises after the 4th sampling edge.
- step_chg and err_pulse are high for exactly one cycle. They never assert together.
- Reset asserted mid-operation: the next edge returns to the reset values, whether the FSM was in ACQ or LOCK. Lock must be re-acquired from scratch.
- Gaps in in_valid do not break lock. Deltas are measured between consecutive valid samples only.
- Wrap-around 15→0 with step 1 is legal (d=1). 14→1 with step 3 is legal (d=3).

## Test plan
- Lock, step 1: after reset, count 0,1,2,3 valid on consecutive cycles -> locked=1, step=1 after the 4th edge; 4,5,…,15,0,1 keeps locked=1 with no pulses.
- Step change: locked at step 1, then count 4,6,8,10 -> step_chg pulses once on the 6, locked drops, then re-locks with step=2 after the 10.
- Error with saturation: locked at step 3 (0,3,6,9), then count 9 (d=0) -> err_pulse once, err_cnt=1, locked=0; force 300 errors -> err_cnt holds 255.
- Wrap and gaps: step 3 stream 9,12,15,2,5 with in_valid low 2 cycles between each sample -> locked=1, step=3, no err_pulse.
- clr with simultaneous error: err_cnt=5, clr=1 on the same edge as an illegal delta -> err_cnt=0, err_pulse=1.
- Reset mid-lock: locked at step 2, rst=0 for one edge -> all outputs 0; the next 4 samples 7,8,9,10 give locked=1, step=1.
